// File: rtl/uart_tx_unit.sv
// UART transmitter for the MIPS peripheral space: a small byte FIFO fed by store
// strobes, drained by an 8N1 serialiser that pulses tx_done at the end of each stop bit.
module uart_tx_unit #(
  parameter int BAUD_DIV   = 10417,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       clr_ovf,
  output logic       full,
  output logic       empty,
  output logic [4:0] count,
  output logic       busy,
  output logic       ovf,
  output logic       tx_done,
  output logic       UART_TX
);

  localparam int               PTR_W     = $clog2(FIFO_DEPTH);
  localparam logic [15:0]      BAUD_LAST = 16'(BAUD_DIV - 1);
  localparam logic [4:0]       DEPTH_CNT = 5'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [4:0]       r_count;
  logic             r_ovf;

  state_t      r_state;
  state_t      w_stateNext;
  logic [15:0] r_baud;
  logic [15:0] w_baudNext;
  logic [2:0]  r_bitIdx;
  logic [2:0]  w_bitNext;
  logic [7:0]  r_shift;
  logic [7:0]  w_shiftNext;
  logic        r_tx;
  logic        w_txNext;
  logic        r_txDone;
  logic        w_txDoneNext;

  logic w_full;
  logic w_accept;
  logic w_drop;
  logic w_pop;
  logic w_bitEnd;

  // Fullness is judged on the registered count, so a pop in the same cycle cannot rescue a write.
  assign w_full   = (r_count == DEPTH_CNT);
  assign w_accept = wr_en & ~w_full;
  assign w_drop   = wr_en & w_full;
  assign w_bitEnd = (r_baud == BAUD_LAST);

  always_ff @(posedge sysclk) begin
    if (w_accept) r_mem[r_wrPtr] <= wr_data;
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_accept) r_wrPtr <= r_wrPtr + PTR_ONE;
      if (w_pop)    r_rdPtr <= r_rdPtr + PTR_ONE;
      r_count <= r_count + {4'b0, w_accept} - {4'b0, w_pop};
      if (w_drop)       r_ovf <= 1'b1;
      else if (clr_ovf) r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_baud   <= '0;
      r_bitIdx <= '0;
      r_shift  <= '0;
      r_tx     <= 1'b1;
      r_txDone <= 1'b0;
    end else begin
      r_state  <= w_stateNext;
      r_baud   <= w_baudNext;
      r_bitIdx <= w_bitNext;
      r_shift  <= w_shiftNext;
      r_tx     <= w_txNext;
      r_txDone <= w_txDoneNext;
    end
  end

  // The serial line value is computed one cycle ahead so UART_TX always comes straight from r_tx.
  always_comb begin
    w_stateNext  = r_state;
    w_baudNext   = r_baud;
    w_bitNext    = r_bitIdx;
    w_shiftNext  = r_shift;
    w_txNext     = r_tx;
    w_txDoneNext = 1'b0;
    w_pop        = 1'b0;
    case (r_state)
      IDLE: begin
        w_txNext = 1'b1;
        if (r_count != 5'd0) begin
          w_pop       = 1'b1;
          w_shiftNext = r_mem[r_rdPtr];
          w_bitNext   = 3'd0;
          w_baudNext  = 16'd0;
          w_txNext    = 1'b0;
          w_stateNext = START;
        end
      end
      START: begin
        if (w_bitEnd) begin
          w_baudNext  = 16'd0;
          w_bitNext   = 3'd0;
          w_txNext    = r_shift[0];
          w_stateNext = DATA;
        end else begin
          w_baudNext = r_baud + 16'd1;
        end
      end
      DATA: begin
        if (w_bitEnd) begin
          w_baudNext = 16'd0;
          if (r_bitIdx == 3'd7) begin
            w_txNext    = 1'b1;
            w_stateNext = STOP;
          end else begin
            w_shiftNext = {1'b0, r_shift[7:1]};
            w_bitNext   = r_bitIdx + 3'd1;
            w_txNext    = r_shift[1];
          end
        end else begin
          w_baudNext = r_baud + 16'd1;
        end
      end
      STOP: begin
        if (w_bitEnd) begin
          w_baudNext   = 16'd0;
          w_txNext     = 1'b1;
          w_txDoneNext = 1'b1;
          w_stateNext  = IDLE;
        end else begin
          w_baudNext = r_baud + 16'd1;
        end
      end
      default: begin
        w_txNext    = 1'b1;
        w_stateNext = IDLE;
      end
    endcase
  end

  assign full    = w_full;
  assign empty   = (r_count == 5'd0);
  assign count   = r_count;
  assign busy    = (r_state != IDLE);
  assign ovf     = r_ovf;
  assign tx_done = r_txDone;
  assign UART_TX = r_tx;

endmodule

// File: tb/tb_uart_tx_unit.sv
// Bench for uart_tx_unit at BAUD_DIV=4, FIFO_DEPTH=4: a serial receiver decodes the line
// and pops expected bytes from a scoreboard queue filled as stimulus is driven.
module tb_uart_tx_unit;

  logic       sysclk;
  logic       reset;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       clr_ovf;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       busy;
  logic       ovf;
  logic       tx_done;
  logic       UART_TX;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rxFrames = 0;
  int doneCount = 0;
  int rxLastStart = 0;
  int rxPrevStart = 0;
  logic [7:0] sb[$];

  uart_tx_unit #(.BAUD_DIV(4), .FIFO_DEPTH(4)) dut (
    .sysclk(sysclk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .clr_ovf(clr_ovf),
    .full(full), .empty(empty), .count(count), .busy(busy), .ovf(ovf),
    .tx_done(tx_done), .UART_TX(UART_TX)
  );

  initial begin
    sysclk = 1'b0;
    forever #5 sysclk = ~sysclk;
  end

  always @(posedge sysclk) cyc <= cyc + 1;

  // Receiver: samples the line mid-bit on falling clock edges and checks each frame against the scoreboard.
  initial begin
    bit rxActive;
    int rxPhase;
    logic [7:0] rxByte;
    logic [7:0] expByte;
    rxActive = 1'b0;
    rxPhase = 0;
    rxByte = 8'h00;
    forever begin
      @(negedge sysclk);
      if (tx_done === 1'b1) doneCount++;
      if (reset === 1'b1) begin
        rxActive = 1'b0;
      end else if (!rxActive) begin
        if (UART_TX === 1'b0) begin
          rxActive = 1'b1;
          rxPhase = 0;
          rxPrevStart = rxLastStart;
          rxLastStart = cyc;
        end
      end else begin
        rxPhase++;
        if (rxPhase == 2) begin
          checks++; if (UART_TX !== 1'b0) begin errors++; $display("[TB] FAIL rx_start_bit: got %b expected 0", UART_TX); end
        end else if (rxPhase >= 6 && rxPhase <= 34 && ((rxPhase - 6) % 4) == 0) begin
          rxByte = {UART_TX, rxByte[7:1]};
        end else if (rxPhase == 38) begin
          checks++; if (UART_TX !== 1'b1) begin errors++; $display("[TB] FAIL rx_stop_bit: got %b expected 1", UART_TX); end
          checks++;
          if (sb.size() == 0) begin
            errors++; $display("[TB] FAIL rx_unexpected_frame: got %02h expected no frame", rxByte);
          end else begin
            expByte = sb.pop_front();
            if (rxByte !== expByte) begin errors++; $display("[TB] FAIL rx_byte: got %02h expected %02h", rxByte, expByte); end
          end
          rxFrames++;
          rxActive = 1'b0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: got no finish expected finish");
    $fatal(1, "[TB] global timeout");
  end

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic writeByte(input logic [7:0] b, input bit expectTx);
    wr_en = 1'b1;
    wr_data = b;
    if (expectTx) sb.push_back(b);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; wr_en = 1'b0; wr_data = 8'h00; clr_ovf = 1'b0;
    tick(); tick();
    checks++; if (UART_TX !== 1'b1) begin errors++; $display("[TB] FAIL reset_tx: got %b expected 1", UART_TX); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (tx_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_tx_done: got %b expected 0", tx_done); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovf: got %b expected 0", ovf); end
    checks++; if (full !== 1'b0) begin errors++; $display("[TB] FAIL reset_full: got %b expected 0", full); end
    checks++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL reset_empty: got %b expected 1", empty); end
    checks++; if (count !== 5'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", count); end
    reset = 1'b0;
    tick(); tick();
    checks++; if (UART_TX !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_tx: got %b expected 1", UART_TX); end
  endtask

  task automatic test_single_byte();
    logic [9:0] frame;
    frame = {1'b1, 8'h55, 1'b0};
    writeByte(8'h55, 1'b1);
    checks++; if (count !== 5'd1) begin errors++; $display("[TB] FAIL single_count_after_write: got %0d expected 1", count); end
    checks++; if (empty !== 1'b0) begin errors++; $display("[TB] FAIL single_empty_after_write: got %b expected 0", empty); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL single_busy_before_pop: got %b expected 0", busy); end
    tick();
    checks++; if (UART_TX !== 1'b0) begin errors++; $display("[TB] FAIL single_start_fall: got %b expected 0", UART_TX); end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL single_busy_rise: got %b expected 1", busy); end
    checks++; if (count !== 5'd0) begin errors++; $display("[TB] FAIL single_count_after_pop: got %0d expected 0", count); end
    for (int c = 1; c < 40; c++) begin
      tick();
      checks++;
      if (UART_TX !== frame[c / 4]) begin
        errors++; $display("[TB] FAIL single_line_cycle%0d: got %b expected %b", c, UART_TX, frame[c / 4]);
      end
    end
    checks++; if (tx_done !== 1'b0) begin errors++; $display("[TB] FAIL single_tx_done_early: got %b expected 0", tx_done); end
    tick();
    checks++; if (tx_done !== 1'b1) begin errors++; $display("[TB] FAIL single_tx_done_pulse: got %b expected 1", tx_done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL single_busy_fall: got %b expected 0", busy); end
    tick();
    checks++; if (tx_done !== 1'b0) begin errors++; $display("[TB] FAIL single_tx_done_width: got %b expected 0", tx_done); end
    checks++; if (sb.size() != 0) begin errors++; $display("[TB] FAIL single_scoreboard: got %0d pending expected 0", sb.size()); end
  endtask

  task automatic test_back_to_back();
    int framesBefore;
    int doneBefore;
    int guard;
    framesBefore = rxFrames;
    doneBefore = doneCount;
    writeByte(8'hA3, 1'b1);
    writeByte(8'h0F, 1'b1);
    guard = 0;
    while (rxFrames < framesBefore + 2 && guard < 150) begin tick(); guard++; end
    checks++; if (guard >= 150) begin errors++; $display("[TB] FAIL b2b_timeout: got %0d frames expected 2", rxFrames - framesBefore); end
    repeat (5) tick();
    checks++; if (rxLastStart - rxPrevStart !== 41) begin errors++; $display("[TB] FAIL b2b_spacing: got %0d expected 41", rxLastStart - rxPrevStart); end
    checks++; if (doneCount - doneBefore !== 2) begin errors++; $display("[TB] FAIL b2b_tx_done_count: got %0d expected 2", doneCount - doneBefore); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_idle: got %b expected 0", busy); end
  endtask

  task automatic test_overflow();
    int doneBefore;
    int guard;
    doneBefore = doneCount;
    writeByte(8'h11, 1'b1);
    tick();
    for (int i = 0; i < 4; i++) writeByte(8'h21 + 8'(i), 1'b1);
    checks++; if (ovf !== 1'b0) begin errors++; $display("[TB] FAIL ovf_before_drop: got %b expected 0", ovf); end
    checks++; if (full !== 1'b1) begin errors++; $display("[TB] FAIL ovf_full_at_four: got %b expected 1", full); end
    writeByte(8'h25, 1'b0);
    checks++; if (count !== 5'd4) begin errors++; $display("[TB] FAIL ovf_count_saturate: got %0d expected 4", count); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("[TB] FAIL ovf_set: got %b expected 1", ovf); end
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    checks++; if (ovf !== 1'b0) begin errors++; $display("[TB] FAIL ovf_clear: got %b expected 0", ovf); end
    guard = 0;
    while ((sb.size() != 0 || busy !== 1'b0 || count !== 5'd0) && guard < 400) begin tick(); guard++; end
    checks++; if (guard >= 400) begin errors++; $display("[TB] FAIL ovf_drain_timeout: got %0d pending expected 0", sb.size()); end
    repeat (50) tick();
    checks++; if (doneCount - doneBefore !== 5) begin errors++; $display("[TB] FAIL ovf_frame_count: got %0d expected 5", doneCount - doneBefore); end
    checks++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL ovf_empty_after: got %b expected 1", empty); end
  endtask

  task automatic test_full_pop();
    int guard;
    writeByte(8'h31, 1'b1);
    tick();
    for (int i = 0; i < 4; i++) writeByte(8'h32 + 8'(i), 1'b1);
    checks++; if (full !== 1'b1) begin errors++; $display("[TB] FAIL fullpop_full: got %b expected 1", full); end
    guard = 0;
    while (tx_done !== 1'b1 && guard < 60) begin tick(); guard++; end
    checks++; if (guard >= 60) begin errors++; $display("[TB] FAIL fullpop_wait_done: got %b expected 1", tx_done); end
    writeByte(8'h77, 1'b0);
    checks++; if (count !== 5'd3) begin errors++; $display("[TB] FAIL fullpop_count: got %0d expected 3", count); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("[TB] FAIL fullpop_ovf: got %b expected 1", ovf); end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL fullpop_busy: got %b expected 1", busy); end
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    guard = 0;
    while ((sb.size() != 0 || busy !== 1'b0 || count !== 5'd0) && guard < 400) begin tick(); guard++; end
    checks++; if (guard >= 400) begin errors++; $display("[TB] FAIL fullpop_drain_timeout: got %0d pending expected 0", sb.size()); end
  endtask

  task automatic test_reset_mid_frame();
    int doneBefore;
    int lowCycles;
    writeByte(8'hFF, 1'b1);
    writeByte(8'hAA, 1'b1);
    writeByte(8'hBB, 1'b1);
    repeat (16) tick();
    checks++; if (count !== 5'd2 || busy !== 1'b1) begin errors++; $display("[TB] FAIL midreset_setup: got count %0d busy %b expected 2 1", count, busy); end
    reset = 1'b1;
    #1;
    sb.delete();
    doneBefore = doneCount;
    checks++; if (UART_TX !== 1'b1) begin errors++; $display("[TB] FAIL midreset_tx: got %b expected 1", UART_TX); end
    checks++; if (count !== 5'd0) begin errors++; $display("[TB] FAIL midreset_count: got %0d expected 0", count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midreset_busy: got %b expected 0", busy); end
    repeat (3) tick();
    reset = 1'b0;
    lowCycles = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (UART_TX !== 1'b1) lowCycles++;
    end
    checks++; if (lowCycles !== 0) begin errors++; $display("[TB] FAIL midreset_line_quiet: got %0d low cycles expected 0", lowCycles); end
    checks++; if (doneCount !== doneBefore) begin errors++; $display("[TB] FAIL midreset_no_done: got %0d pulses expected 0", doneCount - doneBefore); end
    checks++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL midreset_empty: got %b expected 1", empty); end
  endtask

  task automatic test_pointer_wrap();
    int framesBefore;
    int guard;
    int stallTimeout;
    framesBefore = rxFrames;
    stallTimeout = 0;
    for (int i = 0; i < 10; i++) begin
      guard = 0;
      while (full === 1'b1 && guard < 100) begin tick(); guard++; end
      if (guard >= 100) stallTimeout++;
      writeByte(8'(i), 1'b1);
    end
    checks++; if (stallTimeout !== 0) begin errors++; $display("[TB] FAIL wrap_full_stall: got %0d timeouts expected 0", stallTimeout); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("[TB] FAIL wrap_ovf: got %b expected 0", ovf); end
    guard = 0;
    while ((sb.size() != 0 || busy !== 1'b0 || count !== 5'd0) && guard < 800) begin tick(); guard++; end
    checks++; if (guard >= 800) begin errors++; $display("[TB] FAIL wrap_drain_timeout: got %0d pending expected 0", sb.size()); end
    checks++; if (rxFrames - framesBefore !== 10) begin errors++; $display("[TB] FAIL wrap_frame_count: got %0d expected 10", rxFrames - framesBefore); end
    checks++; if (count !== 5'd0) begin errors++; $display("[TB] FAIL wrap_count: got %0d expected 0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL wrap_empty: got %b expected 1", empty); end
  endtask

  initial begin
    reset = 1'b1;
    wr_en = 1'b0;
    wr_data = 8'h00;
    clr_ovf = 1'b0;
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_overflow();
    test_full_pop();
    test_reset_mid_frame();
    test_pointer_wrap();
    repeat (5) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
